sr595_chain_driver: RTL and testbench

SR595_CHAIN_DRIVER -- requirements
Module: sr595_chain_driver

---
 rtl/sr595_pkg.sv | 13 +
 rtl/sr595_tick_gen.sv | 34 +++
 rtl/sr595_chain_driver.sv | 191 +++++++++++++++++++
 tb/tb_sr595_chain_driver.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr595_pkg.sv
// Shared types and constants for the 74HC595 chain driver.
package sr595_pkg;

    localparam int CHIP_BITS = 8;
    localparam int DUTY_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } sr595_state_e;

endpackage

// File: rtl/sr595_tick_gen.sv
// Serial tick divider: pulses tick once every CLK_DIV enabled clk cycles.
module sr595_tick_gen #(
    parameter int CLK_DIV = 6000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Divider count: restarts on frame accept, advances only while a frame is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign tick = enable && (cnt_r == CNT_LAST);

endmodule

// File: rtl/sr595_chain_driver.sv
// Serialises a parallel frame into a chain of 74HC595 shift registers and latches it.
// Optional brightness PWM on OE# is enabled by defining SR595_DIMMING_EN.
module sr595_chain_driver
    import sr595_pkg::*;
#(
    parameter int N_CHIPS   = 2,
    parameter int CLK_DIV   = 6000,
    parameter int LSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHIP_BITS*N_CHIPS-1:0] i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [DUTY_W-1:0]            i_duty,
    output logic                         o_ser,
    output logic                         o_srclk,
    output logic                         o_rclk,
    output logic                         o_oe_n
);

    localparam int W     = CHIP_BITS * N_CHIPS;
    localparam int BIT_W = $clog2(W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

    sr595_state_e     state_r, state_nxt_s;
    logic [W-1:0]     data_r, data_nxt_s;
    logic [BIT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
    logic             phase_r, phase_nxt_s;
    logic             ser_r, ser_nxt_s;
    logic             srclk_r, srclk_nxt_s;
    logic             rclk_r, rclk_nxt_s;
    logic             accept_s;
    logic             run_s;
    logic             tick_s;
    logic             last_bit_s;

    // Bit idx of the frame in shift order (idx 0 goes out first)
    function automatic logic pick_bit(input logic [W-1:0] frame, input logic [BIT_W-1:0] idx);
        if (LSB_FIRST != 0) begin
            pick_bit = frame[idx];
        end else begin
            pick_bit = frame[BIT_LAST - idx];
        end
    endfunction

    assign accept_s   = i_valid && (state_r == IDLE);
    assign run_s      = (state_r != IDLE);
    assign last_bit_s = (bit_cnt_r == BIT_LAST);

    sr595_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (run_s),
        .clear  (accept_s),
        .tick   (tick_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: shift every bit on two ticks, then one tick of latch pulse
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = SHIFT;
                else          state_nxt_s = IDLE;
            end
            SHIFT: begin
                if (tick_s && phase_r && last_bit_s) state_nxt_s = LATCH;
                else                                 state_nxt_s = SHIFT;
            end
            LATCH: begin
                if (tick_s) state_nxt_s = IDLE;
                else        state_nxt_s = LATCH;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output/datapath decode: next values of the serial pins and frame counters
    always_comb begin
        data_nxt_s    = data_r;
        bit_cnt_nxt_s = bit_cnt_r;
        phase_nxt_s   = phase_r;
        ser_nxt_s     = ser_r;
        srclk_nxt_s   = srclk_r;
        rclk_nxt_s    = rclk_r;
        case (state_r)
            IDLE: begin
                srclk_nxt_s = 1'b0;
                rclk_nxt_s  = 1'b0;
                if (accept_s) begin
                    data_nxt_s    = i_data;
                    ser_nxt_s     = pick_bit(i_data, {BIT_W{1'b0}});
                    bit_cnt_nxt_s = {BIT_W{1'b0}};
                    phase_nxt_s   = 1'b0;
                end else begin
                    ser_nxt_s = 1'b0;
                end
            end
            SHIFT: begin
                if (tick_s && !phase_r) begin
                    srclk_nxt_s = 1'b1;
                    phase_nxt_s = 1'b1;
                end else if (tick_s) begin
                    srclk_nxt_s = 1'b0;
                    phase_nxt_s = 1'b0;
                    if (last_bit_s) begin
                        rclk_nxt_s = 1'b1;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
                        ser_nxt_s     = pick_bit(data_r, bit_cnt_r + BIT_W'(1));
                    end
                end else begin
                    srclk_nxt_s = srclk_r;
                end
            end
            LATCH: begin
                if (tick_s) begin
                    rclk_nxt_s    = 1'b0;
                    ser_nxt_s     = 1'b0;
                    bit_cnt_nxt_s = {BIT_W{1'b0}};
                end else begin
                    rclk_nxt_s = rclk_r;
                end
            end
            default: begin
                ser_nxt_s   = 1'b0;
                srclk_nxt_s = 1'b0;
                rclk_nxt_s  = 1'b0;
            end
        endcase
    end

    // Datapath and pin registers; reset discards any partially shifted frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r    <= {W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            phase_r   <= 1'b0;
            ser_r     <= 1'b0;
            srclk_r   <= 1'b0;
            rclk_r    <= 1'b0;
        end else begin
            data_r    <= data_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            phase_r   <= phase_nxt_s;
            ser_r     <= ser_nxt_s;
            srclk_r   <= srclk_nxt_s;
            rclk_r    <= rclk_nxt_s;
        end
    end

    assign o_ready = (state_r == IDLE);
    assign o_ser   = ser_r;
    assign o_srclk = srclk_r;
    assign o_rclk  = rclk_r;

`ifdef SR595_DIMMING_EN
    logic [DUTY_W-1:0] pwm_cnt_r;
    logic              oe_n_r;

    // Free-running PWM: outputs lit while the counter is below the duty value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= {DUTY_W{1'b0}};
            oe_n_r    <= 1'b1;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + DUTY_W'(1);
            oe_n_r    <= (pwm_cnt_r >= i_duty);
        end
    end

    assign o_oe_n = oe_n_r;
`else
    logic duty_unused_s;
    assign duty_unused_s = ^i_duty;
    assign o_oe_n        = 1'b0;
`endif

endmodule

// File: tb/tb_sr595_chain_driver.sv
// Self-checking bench: two driver configurations against a 74HC595 chain model.
module tb_sr595_chain_driver;

    localparam int CD_A = 2;
    localparam int W_A  = 8;
    localparam int CD_B = 1;
    localparam int W_B  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_a = 8'h00;
    logic [15:0] data_b = 16'h0000;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic [7:0]  duty = 8'h00;
    logic        o_ready_a, o_ser_a, o_srclk_a, o_rclk_a, o_oe_n_a;
    logic        o_ready_b, o_ser_b, o_srclk_b, o_rclk_b, o_oe_n_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    sr595_chain_driver #(.N_CHIPS(1), .CLK_DIV(CD_A), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_data(data_a), .i_valid(valid_a), .o_ready(o_ready_a),
        .i_duty(duty), .o_ser(o_ser_a), .o_srclk(o_srclk_a), .o_rclk(o_rclk_a), .o_oe_n(o_oe_n_a)
    );

    sr595_chain_driver #(.N_CHIPS(2), .CLK_DIV(CD_B), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_data(data_b), .i_valid(valid_b), .o_ready(o_ready_b),
        .i_duty(duty), .o_ser(o_ser_b), .o_srclk(o_srclk_b), .o_rclk(o_rclk_b), .o_oe_n(o_oe_n_b)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic int cd(input int d);
        return (d == 0) ? CD_A : CD_B;
    endfunction

    function automatic int wd(input int d);
        return (d == 0) ? W_A : W_B;
    endfunction

    function automatic bit lsbf(input int d);
        return (d == 0);
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? o_ready_a : o_ready_b;
    endfunction

    // Frame as seen on the chain outputs, mapped back to i_data bit positions
    function automatic logic [15:0] decode(input int d, input logic [15:0] s);
        logic [15:0] r = 16'h0000;
        for (int i = 0; i < wd(d); i++) r[i] = lsbf(d) ? s[wd(d)-1-i] : s[i];
        return r;
    endfunction

    function automatic logic exp_bit(input int d, input logic [15:0] dat, input int k);
        return lsbf(d) ? dat[k] : dat[wd(d)-1-k];
    endfunction

    // Chain model and event recorder, sampled on the falling clk edge
    logic [1:0]  ser_v, srclk_v, rclk_v, ready_v;
    logic [1:0]  p_ser = 2'b00, p_srclk = 2'b00, p_rclk = 2'b00, p_ready = 2'b11;
    logic [15:0] chain_sr [2];
    int          rise_q [2][$];
    int          rr_q   [2][$];
    int          rf_q   [2][$];
    int          rdy_q  [2][$];
    logic        bit_q  [2][$];
    logic [15:0] lat_q  [2][$];
    int          last_chg [2] = '{-1000, -1000};
    int          last_rise [2] = '{-1000, -1000};
    int          stab_viol = 0;

    assign ser_v   = {o_ser_b, o_ser_a};
    assign srclk_v = {o_srclk_b, o_srclk_a};
    assign rclk_v  = {o_rclk_b, o_rclk_a};
    assign ready_v = {o_ready_b, o_ready_a};

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                last_rise[d] = -1000;
            end else begin
                if (ser_v[d] !== p_ser[d]) begin
                    if (cyc - last_rise[d] < cd(d)) stab_viol++;
                    last_chg[d] = cyc;
                end
                if (srclk_v[d] && !p_srclk[d]) begin
                    if (cyc - last_chg[d] < cd(d)) stab_viol++;
                    last_rise[d] = cyc;
                    chain_sr[d] = {chain_sr[d][14:0], ser_v[d]};
                    bit_q[d].push_back(ser_v[d]);
                    rise_q[d].push_back(cyc);
                end
                if (rclk_v[d] && !p_rclk[d]) begin
                    rr_q[d].push_back(cyc);
                    lat_q[d].push_back(decode(d, chain_sr[d]));
                end
                if (!rclk_v[d] && p_rclk[d]) rf_q[d].push_back(cyc);
                if (ready_v[d] && !p_ready[d]) rdy_q[d].push_back(cyc);
            end
        end
        p_ser   = ser_v;
        p_srclk = srclk_v;
        p_rclk  = rclk_v;
        p_ready = ready_v;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic [15:0] dat, input logic v);
        if (d == 0) begin
            data_a  = dat[7:0];
            valid_a = v;
        end else begin
            data_b  = dat;
            valid_b = v;
        end
    endtask

    task automatic clear_q(input int d);
        rise_q[d].delete(); rr_q[d].delete(); rf_q[d].delete();
        rdy_q[d].delete();  bit_q[d].delete(); lat_q[d].delete();
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        while (!rdy(d) && n < 300) begin
            step();
            n++;
        end
        check("ready_wait", 64'(rdy(d)), 64'(1'b1));
    endtask

    function automatic int q0(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Compare one recorded frame against the timing rules and the chain contents
    task automatic check_frame(input int d, input logic [15:0] dat, input int t0, input int idx, input string tag);
        int w = wd(d);
        int c = cd(d);
        check({tag, "_nbits"}, 64'(bit_q[d].size()), 64'(w * (idx + 1)));
        for (int k = 0; k < w && (idx * w + k) < bit_q[d].size(); k++) begin
            check($sformatf("%s_bit%0d", tag, k), 64'(bit_q[d][idx*w+k]), 64'(exp_bit(d, dat, k)));
            check($sformatf("%s_rise%0d", tag, k), 64'(rise_q[d][idx*w+k]), 64'(t0 + (2*k+1)*c));
        end
        check({tag, "_rclk_rise"}, 64'(q0(rr_q[d], idx)), 64'(t0 + 2*w*c));
        check({tag, "_rclk_fall"}, 64'(q0(rf_q[d], idx)), 64'(t0 + (2*w+1)*c));
        check({tag, "_ready_back"}, 64'(q0(rdy_q[d], idx)), 64'(t0 + (2*w+1)*c));
        check({tag, "_latched"}, 64'((idx < lat_q[d].size()) ? lat_q[d][idx] : 16'hxxxx), 64'(dat));
    endtask

    task automatic run_frame(input int d, input logic [15:0] dat, input bit scramble, input string tag);
        int t0;
        int n = 0;
        wait_ready(d);
        clear_q(d);
        drive(d, dat, 1'b1);
        t0 = cyc + 1;
        step();
        drive(d, dat, 1'b0);
        while (rf_q[d].size() == 0 && n < 300) begin
            if (scramble) drive(d, 16'($urandom), 1'b0);
            step();
            n++;
        end
        check_frame(d, dat, t0, 0, tag);
    endtask

    initial begin
        int t0;
        int n;
        int low_a;
        int low_b;
        logic [15:0] r;

        // Reset state
        step();
        step();
        check("rst_ready_a", 64'(o_ready_a), 64'(1'b1));
        check("rst_pins_a", 64'({o_ser_a, o_srclk_a, o_rclk_a}), 64'(3'b000));
        check("rst_ready_b", 64'(o_ready_b), 64'(1'b1));
        check("rst_pins_b", 64'({o_ser_b, o_srclk_b, o_rclk_b}), 64'(3'b000));
`ifdef SR595_DIMMING_EN
        check("rst_oe_a", 64'(o_oe_n_a), 64'(1'b1));
`else
        check("rst_oe_a", 64'(o_oe_n_a), 64'(1'b0));
`endif
        rst_n = 1'b1;
        step();

        // Single frame, LSB first, divider 2
        run_frame(0, 16'h00A5, 1'b0, "a5");
        // Data changing every cycle while shifting must not reach the chain
        for (int i = 0; i < 3; i++) begin
            r = 16'($urandom) & 16'h00FF;
            run_frame(0, r, 1'b1, $sformatf("a_rand%0d", i));
        end

        // MSB first, 16 bits, divider 1
        run_frame(1, 16'h8001, 1'b0, "b8001");
        for (int i = 0; i < 3; i++) begin
            r = 16'($urandom);
            run_frame(1, r, 1'b1, $sformatf("b_rand%0d", i));
        end

        // Back-to-back frames with i_valid held high
        wait_ready(0);
        clear_q(0);
        drive(0, 16'h000F, 1'b1);
        t0 = cyc + 1;
        step();
        drive(0, 16'h00F0, 1'b1);
        n = 0;
        while (!(rf_q[0].size() >= 1 && !o_ready_a) && n < 300) begin
            step();
            n++;
        end
        drive(0, 16'h00F0, 1'b0);
        n = 0;
        while (rf_q[0].size() < 2 && n < 300) begin
            step();
            n++;
        end
        check("b2b_first_ready", 64'(q0(rdy_q[0], 0)), 64'(t0 + (2*W_A+1)*CD_A));
        check("b2b_frame2_rise0", 64'(q0(rise_q[0], W_A)), 64'(t0 + (2*W_A+1)*CD_A + 1 + CD_A));
        check("b2b_nframes", 64'(lat_q[0].size()), 64'(2));
        check_frame(0, 16'h00F0, t0 + (2*W_A+1)*CD_A + 1, 1, "b2b_f2");
        check("b2b_latched0", 64'((lat_q[0].size() > 0) ? lat_q[0][0] : 16'hxxxx), 64'(16'h000F));
        step();

        // Reset in the middle of bit 5: nothing may be latched
        wait_ready(0);
        clear_q(0);
        drive(0, 16'h005A, 1'b1);
        step();
        drive(0, 16'h005A, 1'b0);
        n = 0;
        while (bit_q[0].size() < 6 && n < 300) begin
            step();
            n++;
        end
        check("abort_reached_bit5", 64'(bit_q[0].size()), 64'(6));
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_pins", 64'({o_ser_a, o_srclk_a, o_rclk_a}), 64'(3'b000));
        check("abort_ready", 64'(o_ready_a), 64'(1'b1));
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step();
        check("abort_no_rclk", 64'(rr_q[0].size()), 64'(0));
        check("abort_ready_idle", 64'(o_ready_a), 64'(1'b1));
        run_frame(0, 16'h00C3, 1'b0, "after_abort");

        // Output-enable behaviour
`ifdef SR595_DIMMING_EN
        duty = 8'd64;
        step();
        step();
        low_a = 0;
        low_b = 0;
        for (int i = 0; i < 256; i++) begin
            if (o_oe_n_a === 1'b0) low_a++;
            if (o_oe_n_b === 1'b0) low_b++;
            step();
        end
        check("pwm64_low_a", 64'(low_a), 64'(64));
        check("pwm64_low_b", 64'(low_b), 64'(64));
        duty = 8'd0;
        step();
        step();
        low_a = 0;
        for (int i = 0; i < 256; i++) begin
            if (o_oe_n_a !== 1'b1) low_a++;
            step();
        end
        check("pwm0_dark_a", 64'(low_a), 64'(0));
`else
        low_a = 0;
        low_b = 0;
        for (int i = 0; i < 256; i++) begin
            duty = 8'($urandom);
            if (o_oe_n_a === 1'b0) low_a++;
            if (o_oe_n_b === 1'b0) low_b++;
            step();
        end
        check("oe_const_a", 64'(low_a), 64'(256));
        check("oe_const_b", 64'(low_b), 64'(256));
`endif

        check("ser_stability", 64'(stab_viol), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
